// File: rtl/sram_mem_pkg.sv
// -----------------------------------------------------------------------------
// sram_mem_pkg
// Shared definitions for the MEM-stage SRAM responder:
//   - state_t      : responder FSM states (IDLE, LO, HI, DONE)
//   - op_t         : latched operation type (OP_RD / OP_WR)
//   - BASE_ADDR_DEFAULT : CPU byte address that maps to SRAM word 0
//   - SRAM_DW      : external SRAM data width (one half of a CPU word)
// -----------------------------------------------------------------------------
package sram_mem_pkg;

    localparam int unsigned BASE_ADDR_DEFAULT = 1024;
    localparam int unsigned SRAM_DW           = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/sram_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
// 4-bit wait-cycle counter for one 16-bit SRAM half access.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force count to 0 on the next edge (has priority over en)
//   en        : increment on the next edge
//   tc        : current count equals WAIT_CYCLES-1 (last cycle of a phase)
//   tc_next   : count will equal WAIT_CYCLES-1 after the next edge; lets the
//               parent register its SRAM strobes without a cycle of lag
// -----------------------------------------------------------------------------
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc,
    output logic tc_next
);

    localparam logic [3:0] TC_VAL = 4'(WAIT_CYCLES - 1);

    logic [3:0] count_reg;
    logic [3:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = 4'd0;
        end else if (en) begin
            count_next = count_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tc      = (count_reg == TC_VAL);
    assign tc_next = (count_next == TC_VAL);

endmodule

// File: rtl/sram_mem_responder.sv
// -----------------------------------------------------------------------------
// sram_mem_responder
// Services 32-bit MEM-stage loads/stores as two 16-bit accesses (low half,
// then high half) to an external asynchronous SRAM, each lasting WAIT_CYCLES
// clock cycles. ready is low while a request is in flight so the pipeline
// freezes; it is high for one DONE cycle when the word transfer completes.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rd_en, wr_en             : request strobes, held until ready=1
//   address, write_data      : CPU byte address and store data
//   read_data                : load result, updated on entry to DONE, held
//   ready                    : idle with no request, or DONE
//   sram_addr                : SRAM half-word address {word, half}
//   sram_dq_out/in, _oe      : SRAM data bus (split tri-state)
//   sram_we_n/oe_n/ce_n      : active-low SRAM strobes (registered)
//   rd_count, wr_count       : completed-access counters, only when the
//                              SRAM_ACCESS_CNT_EN macro is defined
// -----------------------------------------------------------------------------
module sram_mem_responder
    import sram_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    input  logic [SRAM_DW-1:0]   sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n,
    output logic                 sram_oe_n,
    output logic                 sram_ce_n
`ifdef SRAM_ACCESS_CNT_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);

    localparam int unsigned WORD_W = SRAM_AW - 1;

    state_t state_reg, state_next;
    op_t    op_reg, op_next;

    logic [WORD_W-1:0]  word_reg, word_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [SRAM_DW-1:0] rdata_lo_reg;

    logic req;
    logic start;
    logic cnt_clr, cnt_en, cnt_tc, cnt_tc_next;

    // Address map: offset from BASE_ADDR, word-aligned, truncated so that
    // out-of-range addresses wrap into the SRAM silently.
    logic [31:0]       offset;
    logic [WORD_W-1:0] word_in;
    logic              unused_offset_bits;

    assign offset             = address - 32'(BASE_ADDR);
    assign word_in            = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign req = rd_en | wr_en;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .tc      (cnt_tc),
        .tc_next (cnt_tc_next)
    );

    // ------------------------------------------------------------------
    // FSM next state and counter control
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    start      = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = LO;
                end
            end
            LO: begin
                if (cnt_tc) begin
                    cnt_clr    = 1'b1;
                    state_next = HI;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HI: begin
                if (cnt_tc) begin
                    cnt_clr    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A fresh request is frozen in the same cycle it appears, so ready is
    // combinational from the request strobes while idle.
    assign ready = (state_reg == DONE) || ((state_reg == IDLE) && !req);

    // Request fields as they will be after this edge. Write wins when both
    // strobes are high.
    always_comb begin
        op_next    = op_reg;
        word_next  = word_reg;
        wdata_next = wdata_reg;
        if (start) begin
            op_next    = wr_en ? OP_WR : OP_RD;
            word_next  = word_in;
            wdata_next = write_data;
        end
    end

    // ------------------------------------------------------------------
    // SRAM pin values for the cycle after this edge. The pins are
    // registered so the asynchronous SRAM never sees decode glitches.
    // ------------------------------------------------------------------
    logic [SRAM_AW-1:0] sram_addr_next;
    logic [SRAM_DW-1:0] sram_dq_out_next;
    logic               sram_dq_oe_next;
    logic               sram_we_n_next;
    logic               sram_oe_n_next;
    logic               sram_ce_n_next;
    logic               phase_hi_next;

    always_comb begin
        sram_addr_next   = sram_addr;
        sram_dq_out_next = sram_dq_out;
        sram_dq_oe_next  = 1'b0;
        sram_we_n_next   = 1'b1;
        sram_oe_n_next   = 1'b1;
        sram_ce_n_next   = 1'b1;
        phase_hi_next    = (state_next == HI);
        if ((state_next == LO) || (state_next == HI)) begin
            sram_ce_n_next = 1'b0;
            sram_addr_next = {word_next, phase_hi_next};
            if (op_next == OP_WR) begin
                sram_dq_oe_next  = 1'b1;
                sram_dq_out_next = phase_hi_next ? wdata_next[31:16] : wdata_next[15:0];
                // Strobe drops for all but the final cycle of the phase,
                // which holds data stable while we_n rises. A one-cycle
                // phase has no room for a hold cycle.
                sram_we_n_next   = (WAIT_CYCLES > 1) ? cnt_tc_next : 1'b0;
            end else begin
                sram_oe_n_next = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, request latch, read staging and SRAM pin registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg       <= OP_RD;
            word_reg     <= '0;
            wdata_reg    <= 32'd0;
            rdata_lo_reg <= '0;
            read_data    <= 32'd0;
            sram_addr    <= '0;
            sram_dq_out  <= '0;
            sram_dq_oe   <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_ce_n    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            word_reg    <= word_next;
            wdata_reg   <= wdata_next;
            sram_addr   <= sram_addr_next;
            sram_dq_out <= sram_dq_out_next;
            sram_dq_oe  <= sram_dq_oe_next;
            sram_we_n   <= sram_we_n_next;
            sram_oe_n   <= sram_oe_n_next;
            sram_ce_n   <= sram_ce_n_next;
            // SRAM output has had the whole phase to settle by its last cycle.
            if ((state_reg == LO) && cnt_tc && (op_reg == OP_RD)) begin
                rdata_lo_reg <= sram_dq_in;
            end
            if ((state_reg == HI) && cnt_tc && (op_reg == OP_RD)) begin
                read_data <= {sram_dq_in, rdata_lo_reg};
            end
        end
    end

`ifdef SRAM_ACCESS_CNT_EN
    // Completed-access counters, bumped on entry to DONE, saturating.
    logic done_entry;
    assign done_entry = (state_reg == HI) && (state_next == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (done_entry) begin
            if ((op_reg == OP_RD) && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if ((op_reg == OP_WR) && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_responder
// Directed stimulus with a scoreboard. Each request pushes its hand-computed
// expectation; a negedge monitor (which also models the async SRAM) pops and
// checks it when the DUT shows DONE (ready high while a request is held).
// -----------------------------------------------------------------------------
module tb_sram_mem_responder;

    localparam int AW = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [AW-1:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;
`ifdef SRAM_ACCESS_CNT_EN
    logic [15:0] rd_count, wr_count;
`endif

    always #5 clk = ~clk;

    sram_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ce_n   (sram_ce_n)
`ifdef SRAM_ACCESS_CNT_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [15:0] mem [0:(1<<AW)-1];
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_wr;
        logic [17:0] lo;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    bit          pend_v = 1'b0;
    logic [17:0] pend_a;
    logic [15:0] pend_d;
    int          busy, ce_cyc, we_low, oe_low, commits;
    logic [17:0] lo_seen, hi_seen, hi_exp;
    exp_t        e;

    task automatic clear_acc();
        busy = 0; ce_cyc = 0; we_low = 0; oe_low = 0; commits = 0;
        lo_seen = '0; hi_seen = '0;
    endtask

    initial clear_acc();

    always @(negedge clk) begin
        // Write commits at the end of a we_n pulse if the chip is still
        // selected; a pulse cut short by ce_n rising is discarded.
        if (pend_v && !sram_ce_n && (sram_we_n || sram_addr != pend_a)) begin
            mem[pend_a] = pend_d;
            pend_v = 1'b0;
            commits++;
        end
        if (sram_ce_n) pend_v = 1'b0;
        if (!sram_ce_n && !sram_we_n) begin
            pend_v = 1'b1;
            pend_a = sram_addr;
            pend_d = sram_dq_out;
            chk("dq_oe_on_we", {31'd0, sram_dq_oe}, 32'd1);
        end

        if (rst) begin
            clear_acc();
        end else begin
            if (!ready) busy++;
            if (!sram_ce_n) begin
                if (ce_cyc == 0) lo_seen = sram_addr;
                hi_seen = sram_addr;
                ce_cyc++;
            end
            if (!sram_we_n) we_low++;
            if (!sram_oe_n) oe_low++;
            if (ready && (rd_en || wr_en)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got a DONE, expected none");
                end else begin
                    e = sb.pop_front();
                    hi_exp = e.lo + 18'd1;
                    chk("busy_cycles", busy, 32'd7);
                    chk("ce_cycles", ce_cyc, 32'd6);
                    chk("lo_addr", {14'd0, lo_seen}, {14'd0, e.lo});
                    chk("hi_addr", {14'd0, hi_seen}, {14'd0, hi_exp});
                    chk("read_data", read_data, e.rdata);
                    if (e.is_wr) begin
                        chk("we_low_cycles", we_low, 32'd4);
                        chk("oe_low_cycles", oe_low, 32'd0);
                        chk("commits", commits, 32'd2);
                        chk("mem_lo", {16'd0, mem[e.lo]}, {16'd0, e.wdata[15:0]});
                        chk("mem_hi", {16'd0, mem[hi_exp]}, {16'd0, e.wdata[31:16]});
                    end else begin
                        chk("we_low_cycles", we_low, 32'd0);
                        chk("oe_low_cycles", oe_low, 32'd6);
                        chk("commits", commits, 32'd0);
                    end
                end
                clear_acc();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [17:0] lo,
                       input logic [31:0] exp_rd);
        exp_t x;
        bit   got;
        x.is_wr = wr;
        x.lo    = lo;
        x.rdata = exp_rd;
        x.wdata = wd;
        sb.push_back(x);
        rd_en = rd; wr_en = wr; address = a; write_data = wd;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no ready, expected ready within 40 cycles (addr 0x%08h)", a);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        $display("txn rd=%0d wr=%0d addr=0x%08h wdata=0x%08h read_data=0x%08h", rd, wr, a, wd, read_data);
    endtask

    int start_cyc;

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0000;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        address = 32'd0; write_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        @(posedge clk);
        #1;

        txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0000_0000);
        txn(1'b1, 1'b0, 32'd1024, 32'h0,        18'd0, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("read_data_hold", read_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        txn(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 18'd6,       32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'd1036, 32'h0,        18'd6,       32'hCAFEF00D);
        txn(1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, 18'h3FFFE,   32'hCAFEF00D);
        txn(1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE,   32'h0BADC0DE);
        // Both strobes: write wins, read_data untouched.
        txn(1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2,       32'h0BADC0DE);
        txn(1'b1, 1'b0, 32'd1028, 32'h0,        18'd2,       32'h12345678);

        // Reset while the HI half of a write is in progress.
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h55556666;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("midrst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("midrst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_read_data", read_data, 32'd0);
        chk("midrst_mem0", {16'd0, mem[0]}, 32'h0000_6666);
        chk("midrst_mem1", {16'd0, mem[1]}, 32'h0000_DEAD);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        $display("txn reset during write HI phase at addr 0x%08h", 32'd1024);

        txn(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'hDEAD6666);

        // Back-to-back: read held through DONE, then a write with no gap.
        start_cyc = cyc;
        txn(1'b1, 1'b0, 32'd1036, 32'h0,        18'd6, 32'hCAFEF00D);
        txn(1'b0, 1'b1, 32'd1040, 32'hA5A55A5A, 18'd8, 32'hCAFEF00D);
        chk("b2b_cycles", cyc - start_cyc, 32'd16);
        txn(1'b1, 1'b0, 32'd1040, 32'h0,        18'd8, 32'hA5A55A5A);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Responder side of the MEM-stage data-memory interface.
- Accepts 32-bit word read/write requests from the MEM stage and services each one as two 16-bit accesses to an external asynchronous SRAM. Each access has a fixed number of wait cycles.
- Drives `ready` low while busy; top level uses `~ready` as a pipeline-wide freeze.
- Replaces the single-cycle data memory behind the MEM stage.

Parameters:
- BASE_ADDR, 1024: CPU byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM address width (16-bit words).
- WAIT_CYCLES, 3: cycles per 16-bit half access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- rd_en  in  1  MEM-stage read request; held until ready=1.
- wr_en  in  1  MEM-stage write request; held until ready=1.
- address  in  32  CPU byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  load data; valid in the DONE cycle, held until the next read completes.
- ready  out  1  transaction complete / responder idle.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data returned from SRAM.
- sram_dq_oe  out  1  tri-state enable for sram_dq_out.
- sram_we_n  out  1  active-low write strobe.
- sram_oe_n  out  1  active-low output enable.
- sram_ce_n  out  1  active-low chip enable.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst sampled at the clock edge; it overrides everything, including mid-transaction.
  - Reset values: state=IDLE, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1, sram_ce_n=1, wait counter=0.
  - ready=1 after reset, since there is no request.
- Address map:
  - word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Low half uses sram_addr {word,0}; high half uses {word,1}.
  - Out-of-range addresses wrap silently; no error is flagged.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: on wr_en|rd_en, latch address, write_data and op, then go to LO with counter=0. If both are high, the write wins and read_data is untouched.
  - LO / HI: counter increments each cycle. At counter==WAIT_CYCLES-1, clear the counter and advance LO→HI→DONE.
  - DONE: lasts one cycle, then returns to IDLE unconditionally.
- ready (combinational):
  - 1 in DONE.
  - 1 in IDLE when rd_en|wr_en is low.
  - 0 otherwise.
  - A request is therefore frozen starting in the same cycle it appears. ready stays low for 1+2*WAIT_CYCLES cycles, then is high for exactly 1 cycle (DONE).
  - In DONE the pipeline advances. The request seen in the following IDLE cycle belongs to the next instruction and starts a new transaction with no gap.
- Write phases:
  - sram_ce_n=0 and sram_dq_oe=1 for the whole phase.
  - sram_dq_out = write_data[15:0] in LO, write_data[31:16] in HI.
  - sram_we_n=0 for every phase cycle except the last (data hold). With WAIT_CYCLES=1, sram_we_n=0 for that single cycle.
- Read phases:
  - sram_ce_n=0, sram_oe_n=0, sram_dq_oe=0.
  - sram_dq_in is captured at the last phase cycle's edge into the low or high staging half.
  - read_data is updated with the full word on entering DONE.
- Outside LO/HI, all SRAM strobes are inactive.

Optional Feature:
- Macro: SRAM_ACCESS_CNT_EN.
- When defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each counter increments on entry to DONE for its op type and saturates at 0xFFFF.
  - Both reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_mem_pkg holds:
  - the state enum (IDLE/LO/HI/DONE);
  - the BASE_ADDR default;
  - the SRAM data width constant (16);
  - the op encoding (OP_RD / OP_WR).
- One sub-module, sram_wait_counter: a 4-bit counter with clear/enable and a terminal-count output at WAIT_CYCLES-1.

Test Plan:
- Write: wr_en, address=1024, data=0xDEADBEEF, WAIT_CYCLES=3 → sram_addr 0 gets 0xBEEF, then sram_addr 1 gets 0xDEAD. we_n pulses are 2 cycles each. ready is low 7 cycles, then high 1 cycle.
- Read back: rd_en, address=1024 → sram_dq_in model returns 0xBEEF/0xDEAD → read_data=0xDEADBEEF in the DONE cycle, and it stays after the request drops.
- Map: address=1036 → sram_addr sequence 6, 7. Address=1020 → word wraps to 2^(SRAM_AW-1)-1.
- Reset mid-op: rst asserted during the HI phase of a write → next cycle is IDLE with we_n=1, dq_oe=0, ready=1. Address 1 is never written.
- Conflict: rd_en=wr_en=1 at address 1028 with data 0x12345678 → a write is performed, and read_data keeps its previous value.
- Back-to-back: a read held through DONE is followed immediately by a write to a new address → the write's LO phase starts 1 cycle after DONE. Total is 2×8 cycles with no lost or duplicated transaction.
